// File: rtl/fetch_issue_queue.sv
// Dual-entry-per-cycle instruction queue between fetch and dual-issue decode.
// Buffers fetched instructions in program order and presents the two oldest to decode.
module fetch_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid_1,
    input  logic          in_valid_2,
    input  logic [31:0]   in_pc_1,
    input  logic [31:0]   in_pc_2,
    input  logic [31:0]   in_instr_1,
    input  logic [31:0]   in_instr_2,
    output logic          in_ready,
    output logic          out_valid_1,
    output logic          out_valid_2,
    output logic [31:0]   out_pc_1,
    output logic [31:0]   out_pc_2,
    output logic [31:0]   out_instr_1,
    output logic [31:0]   out_instr_2,
    output logic          out_adel_1,
    output logic          out_adel_2,
    input  logic          deq_1,
    input  logic          deq_2,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          adel_mem  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic          pop_1;
    logic          pop_2;

    // in_ready looks only at the registered count, keeping deq off its timing path
    assign in_ready    = (count <= CW'(DEPTH - 2));
    assign out_valid_1 = (count != '0);
    assign out_valid_2 = (count >= CW'(2));

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    assign n_push = (in_ready && in_valid_1) ? (in_valid_2 ? 2'd2 : 2'd1) : 2'd0;
    assign pop_1  = deq_1 && out_valid_1;
    assign pop_2  = pop_1 && deq_2 && out_valid_2;
    assign n_pop  = {1'b0, pop_1} + {1'b0, pop_2};

    assign out_pc_1    = pc_mem[head];
    assign out_pc_2    = pc_mem[head_p1];
    assign out_instr_1 = instr_mem[head];
    assign out_instr_2 = instr_mem[head_p1];
    assign out_adel_1  = adel_mem[head];
    assign out_adel_2  = adel_mem[head_p1];

    // Flush wipes the queue exactly like reset, but on the clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                adel_mem[i]  <= 1'b0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                adel_mem[i]  <= 1'b0;
            end
        end else begin
            if (n_push != 2'd0) begin
                pc_mem[tail]    <= in_pc_1;
                instr_mem[tail] <= in_instr_1;
                adel_mem[tail]  <= (in_pc_1[1:0] != 2'b00);
            end
            if (n_push == 2'd2) begin
                pc_mem[tail_p1]    <= in_pc_2;
                instr_mem[tail_p1] <= in_instr_2;
                adel_mem[tail_p1]  <= (in_pc_2[1:0] != 2'b00);
            end
            tail  <= tail + AW'(n_push);
            head  <= head + AW'(n_pop);
            count <= count + CW'(n_push) - CW'(n_pop);
        end
    end
endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Dual-entry-per-cycle instruction queue between the fetch front end and the dual-issue decode stage. It accepts up to two fetched instructions per cycle, buffers them in program order in a circular store, and always presents the two oldest entries to decode as slot 1 and slot 2. Decode retires zero, one or both presented slots per cycle, which covers hazard-induced single issue. A flush on redirect, exception or ERET discards everything buffered.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 4
- CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  discard all entries this edge (jump redirect / exception / ERET)
- in_valid_1  in  1  enqueue request, older instruction
- in_valid_2  in  1  enqueue request, younger instruction; honoured only with in_valid_1
- in_pc_1, in_pc_2  in  32  fetch PCs
- in_instr_1, in_instr_2  in  32  instruction words
- in_ready  out  1  queue can take two entries: count ≤ DEPTH-2
- out_valid_1  out  1  slot 1 (oldest entry) present: count ≥ 1
- out_valid_2  out  1  slot 2 (second oldest) present: count ≥ 2
- out_pc_1, out_pc_2  out  32  PCs of slots 1/2
- out_instr_1, out_instr_2  out  32  instruction words of slots 1/2
- out_adel_1, out_adel_2  out  1  fetch address-error flag of slots 1/2
- deq_1  in  1  decode consumed slot 1
- deq_2  in  1  decode consumed slot 2; honoured only with deq_1
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- State: storage[DEPTH] of {pc, instr, adel}, head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH), count register.
- Push, effective count n_push:
  - n_push = 0 if !in_ready or !in_valid_1.
  - Otherwise n_push = 1 + in_valid_2.
  - Entry 1 is written at tail, entry 2 at tail+1 (mod DEPTH); tail advances by n_push.
  - Requests made while in_ready=0 are dropped; the fetcher holds them.
- adel is computed at push as pc[1:0] != 2'b00 and stored with the entry.
- Pop, effective count n_pop:
  - a1 = deq_1 && out_valid_1; a2 = a1 && deq_2 && out_valid_2.
  - n_pop = a1 + a2; head advances by n_pop.
  - deq_2 without deq_1 is ignored.
- Update rule: count_next = count + n_push − n_pop; simultaneous push and pop are legal in one cycle.
- in_ready uses the pre-pop count, so it is conservative and never depends on deq inputs (no combinational path deq→in_ready).
- Outputs are combinational reads of storage[head] and storage[head+1 mod DEPTH].
- out_* data are don't-care when the matching out_valid is 0.
- Flush: head = tail = 0, count = 0; pushes and pops in that cycle are ignored. Flush has priority over everything except reset.
- Program order is preserved: slot 1 is always older than slot 2, and entry 1 is always enqueued before entry 2.

## Timing
- Reset values:
  - in_ready = 1, count = 0, out_valid_1 = out_valid_2 = 0.
  - Storage cleared to 0, so out_pc_*, out_instr_* and out_adel_* read 0.
- Enqueue-to-visible latency is 1 cycle: an entry pushed at edge t is presented from cycle t+1.
- Dequeue takes effect at the clock edge; next presented entries appear the following cycle.
- Full (count = DEPTH): in_ready = 0; pops still proceed.
- count = DEPTH-1: in_ready = 0, because a single-entry push is also blocked. This rule is intentional and simplifies the fetcher.
- Empty: both out_valid = 0; deq inputs are ignored.
- count = 1: only slot 1 is valid; deq_2 is ignored even when asserted.
- Wrap-around: a two-entry push or pop across index DEPTH-1→0 must split correctly.
- Reset asserted mid-operation: state clears immediately (asynchronous); the first push after deassertion lands at index 0.
- Flush and reset behave identically on state, except that flush is synchronous.

## Test plan
- Reset, then push {0xBFC00000, 0xBFC00004}; next cycle: out_valid_1 = out_valid_2 = 1, out_pc_1 = 0xBFC00000, out_pc_2 = 0xBFC00004, count = 2, adel = 0.
- Fill: push pairs continuously with no deq, DEPTH = 8; after 3 pairs count = 6 and in_ready = 1; after the 4th pair count = 8 and in_ready = 0. A 5th request is dropped and count stays 8.
- Partial issue: 4 entries PC A..D, assert deq_1 only; next cycle slot 1 = B, slot 2 = C. Then assert deq_2 alone; nothing changes.
- Simultaneous: count = 6, push 2 and deq 2 in one cycle; count stays 6 and order is preserved across the index 7→0 wrap.
- Flush with in_valid_1 = deq_1 = 1 in the same cycle: next cycle count = 0, out_valid_1 = 0, and the pushed entry is discarded.
- Misaligned PC: push pc = 0x80000002; next cycle out_adel_1 = 1. Asynchronous reset asserted mid-cycle clears count to 0 without waiting for a clock edge.
